// File: rtl/axi_bridge_ip_rx_pkg.sv
// axi_bridge_ip_rx_pkg: shared types and widths for the RX statistics block
package axi_bridge_ip_rx_pkg;
  typedef enum logic {IDLE, IN_FRAME} rx_stats_state_e;
  localparam int ACC_W = 16;
  localparam int PROTO_W = 16;
  localparam int STAT_OUT_W = 16;
endpackage

// File: rtl/axi_bridge_ip_rx_sat_cnt.sv
// axi_bridge_ip_rx_sat_cnt: saturating counter with sync clear that still absorbs this cycle's increment
module axi_bridge_ip_rx_sat_cnt #(
  parameter int W = 32,
  parameter int IW = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic [IW-1:0] inc_i,
  output logic [W-1:0]  cnt_o
);
  localparam int SW = (W > IW ? W : IW) + 1;
  logic [W-1:0] r_cnt;
  logic [SW-1:0] w_sum;
  assign w_sum = SW'(clr_i ? {W{1'b0}} : r_cnt) + SW'(inc_i);
  assign cnt_o = r_cnt;
  always_ff @(posedge clk_i)
    if (rst_i) r_cnt <= '0;
    else r_cnt <= (w_sum > SW'({W{1'b1}})) ? {W{1'b1}} : w_sum[W-1:0];
endmodule

// File: rtl/axi_bridge_ip_rx_stats.sv
// axi_bridge_ip_rx_stats: RX frame/byte/error/drop/protocol counters with FIFO watermark
// and a snapshot/clear handshake for coherent software reads.
module axi_bridge_ip_rx_stats
  import axi_bridge_ip_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BEAT_BYTES = 8,
  parameter int CNT_W = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              beat_valid_i,
  input  logic                              beat_sof_i,
  input  logic                              beat_eof_i,
  input  logic [$clog2(BEAT_BYTES+1)-1:0]   beat_bytes_i,
  input  logic                              beat_err_i,
  input  logic                              drop_i,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_i,
  input  logic                              snap_req_i,
  input  logic                              clr_i,
  output logic                              snap_ack_o,
  output logic [CNT_W-1:0]                  stat_rx_frames_o,
  output logic [CNT_W-1:0]                  stat_rx_bytes_o,
  output logic [CNT_W-1:0]                  stat_rx_err_frames_o,
  output logic [CNT_W-1:0]                  stat_rx_drop_beats_o,
  output logic [15:0]                       stat_rx_proto_err_o,
  output logic [15:0]                       stat_rx_fifo_level_o,
  output logic [15:0]                       stat_rx_fifo_hwm_o
);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  rx_stats_state_e r_state;
  logic [ACC_W-1:0] r_acc, w_acc_sum, w_commit_bytes;
  logic [ACC_W:0] w_add;
  logic r_bad, r_ack, w_in, w_start, w_commit, w_bad, w_good, w_errf, w_proto;
  logic [LW-1:0] r_level, r_hwm, w_hwm_base;
  logic [CNT_W-1:0] w_frames, w_bytes, w_errs, w_drops;
  logic [PROTO_W-1:0] w_proto_cnt;
  logic [CNT_W-1:0] r_snap_frames, r_snap_bytes, r_snap_errs, r_snap_drops;
  logic [PROTO_W-1:0] r_snap_proto;
  assign w_in = r_state == IN_FRAME;
  assign w_start = beat_valid_i & beat_sof_i;
  // IDLE without SOF, or SOF while a frame is still open
  assign w_proto = beat_valid_i & (w_in == beat_sof_i);
  assign w_add = {1'b0, r_acc} + (ACC_W+1)'(beat_bytes_i);
  assign w_acc_sum = w_add[ACC_W] ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];
  assign w_commit_bytes = beat_sof_i ? ACC_W'(beat_bytes_i) : w_acc_sum;
  assign w_commit = beat_valid_i & beat_eof_i & (beat_sof_i | w_in);
  assign w_bad = (beat_sof_i ? 1'b0 : r_bad) | drop_i | beat_err_i;
  assign w_good = w_commit & ~w_bad;
  assign w_errf = w_commit & w_bad;
  assign w_hwm_base = clr_i ? '0 : r_hwm;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_state <= IDLE;
      r_acc <= '0;
      r_bad <= 1'b0;
    end else if (w_start) begin
      r_state <= beat_eof_i ? IDLE : IN_FRAME;
      r_acc <= ACC_W'(beat_bytes_i);
      r_bad <= drop_i;
    end else if (w_in) begin
      r_state <= (beat_valid_i & beat_eof_i) ? IDLE : IN_FRAME;
      r_acc <= beat_valid_i ? w_acc_sum : r_acc;
      r_bad <= r_bad | drop_i;
    end
  axi_bridge_ip_rx_sat_cnt #(.W(CNT_W), .IW(1)) u_frames (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .inc_i(w_good), .cnt_o(w_frames));
  axi_bridge_ip_rx_sat_cnt #(.W(CNT_W), .IW(ACC_W)) u_bytes (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
    .inc_i(w_good ? w_commit_bytes : {ACC_W{1'b0}}), .cnt_o(w_bytes));
  axi_bridge_ip_rx_sat_cnt #(.W(CNT_W), .IW(1)) u_errs (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .inc_i(w_errf), .cnt_o(w_errs));
  axi_bridge_ip_rx_sat_cnt #(.W(CNT_W), .IW(1)) u_drops (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .inc_i(drop_i), .cnt_o(w_drops));
  axi_bridge_ip_rx_sat_cnt #(.W(PROTO_W), .IW(1)) u_proto (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .inc_i(w_proto), .cnt_o(w_proto_cnt));
  // Snapshot samples counter registers before this edge, so a same-cycle clear reads pre-clear values
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_ack <= 1'b0;
      r_level <= '0;
      r_hwm <= '0;
      r_snap_frames <= '0;
      r_snap_bytes <= '0;
      r_snap_errs <= '0;
      r_snap_drops <= '0;
      r_snap_proto <= '0;
    end else begin
      r_ack <= snap_req_i;
      r_level <= fifo_level_i;
      r_hwm <= (fifo_level_i > w_hwm_base) ? fifo_level_i : w_hwm_base;
      if (snap_req_i) begin
        r_snap_frames <= w_frames;
        r_snap_bytes <= w_bytes;
        r_snap_errs <= w_errs;
        r_snap_drops <= w_drops;
        r_snap_proto <= w_proto_cnt;
      end
    end
  assign snap_ack_o = r_ack;
  assign stat_rx_frames_o = r_snap_frames;
  assign stat_rx_bytes_o = r_snap_bytes;
  assign stat_rx_err_frames_o = r_snap_errs;
  assign stat_rx_drop_beats_o = r_snap_drops;
  assign stat_rx_proto_err_o = r_snap_proto;
  assign stat_rx_fifo_level_o = STAT_OUT_W'(r_level);
  assign stat_rx_fifo_hwm_o = STAT_OUT_W'(r_hwm);
endmodule

// File: tb/tb_axi_bridge_ip_rx_stats.sv
// tb_axi_bridge_ip_rx_stats: table-driven directed checks plus watermark, saturation and reset sequences
module tb_axi_bridge_ip_rx_stats;
  logic clk = 1'b0, rst = 1'b1;
  logic valid = 0, sof = 0, eof = 0, err = 0, drop = 0, snap = 0, clr = 0;
  logic [3:0] nbytes = '0;
  logic [4:0] level = '0;
  logic ack, ack4;
  logic [31:0] frames, bytes_o, errs, drops;
  logic [3:0] frames4, bytes4, errs4, drops4;
  logic [15:0] proto, lvl_o, hwm, proto4, lvl4, hwm4;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  axi_bridge_ip_rx_stats dut (
    .clk_i(clk), .rst_i(rst), .beat_valid_i(valid), .beat_sof_i(sof), .beat_eof_i(eof),
    .beat_bytes_i(nbytes), .beat_err_i(err), .drop_i(drop), .fifo_level_i(level),
    .snap_req_i(snap), .clr_i(clr), .snap_ack_o(ack), .stat_rx_frames_o(frames),
    .stat_rx_bytes_o(bytes_o), .stat_rx_err_frames_o(errs), .stat_rx_drop_beats_o(drops),
    .stat_rx_proto_err_o(proto), .stat_rx_fifo_level_o(lvl_o), .stat_rx_fifo_hwm_o(hwm));
  axi_bridge_ip_rx_stats #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .beat_valid_i(valid), .beat_sof_i(sof), .beat_eof_i(eof),
    .beat_bytes_i(nbytes), .beat_err_i(err), .drop_i(drop), .fifo_level_i(level),
    .snap_req_i(snap), .clr_i(clr), .snap_ack_o(ack4), .stat_rx_frames_o(frames4),
    .stat_rx_bytes_o(bytes4), .stat_rx_err_frames_o(errs4), .stat_rx_drop_beats_o(drops4),
    .stat_rx_proto_err_o(proto4), .stat_rx_fifo_level_o(lvl4), .stat_rx_fifo_hwm_o(hwm4));

  typedef struct {
    logic v, s, e;
    logic [3:0] by;
    logic er, dr, sn, cl, ck;
    int f, b, ef, d, p;
  } vec_t;
  vec_t tbl[25];

  function automatic vec_t mk(logic v, s, e, logic [3:0] by, logic er, dr, sn, cl, ck,
                              int f = 0, int b = 0, int ef = 0, int d = 0, int p = 0);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.by = by; r.er = er; r.dr = dr; r.sn = sn; r.cl = cl; r.ck = ck;
    r.f = f; r.b = b; r.ef = ef; r.d = d; r.p = p;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, s, e, input logic [3:0] by, input logic er, dr, sn, cl,
                       input logic [4:0] lv);
    @(negedge clk);
    valid = v; sof = s; eof = e; nbytes = by; err = er; drop = dr; snap = sn; clr = cl; level = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_frames"}, frames, 0);
    chk({tag, "_bytes"}, bytes_o, 0);
    chk({tag, "_errs"}, errs, 0);
    chk({tag, "_drops"}, drops, 0);
    chk({tag, "_proto"}, 32'(proto), 0);
    chk({tag, "_level"}, 32'(lvl_o), 0);
    chk({tag, "_hwm"}, 32'(hwm), 0);
  endtask

  initial begin
    tbl[0]  = mk(1,1,0,8,0,0,0,0,0);
    tbl[1]  = mk(1,0,0,8,0,0,0,0,0);
    tbl[2]  = mk(1,0,1,5,0,0,0,0,0);
    tbl[3]  = mk(0,0,0,0,0,0,1,0,1, 1,21,0,0,0);
    tbl[4]  = mk(1,1,1,4,1,0,0,1,0);
    tbl[5]  = mk(0,0,0,0,0,0,1,0,1, 0,0,1,0,0);
    tbl[6]  = mk(1,1,0,8,0,0,0,0,0);
    tbl[7]  = mk(1,1,1,3,0,0,0,0,0);
    tbl[8]  = mk(1,0,0,2,0,0,0,0,0);
    tbl[9]  = mk(0,0,0,0,0,0,1,0,1, 1,3,1,0,2);
    tbl[10] = mk(1,1,0,8,0,0,0,0,0);
    tbl[11] = mk(1,0,0,8,0,1,0,0,0);
    tbl[12] = mk(1,0,1,6,0,0,0,0,0);
    tbl[13] = mk(0,0,0,0,0,1,0,0,0);
    tbl[14] = mk(0,0,0,0,0,1,0,0,0);
    tbl[15] = mk(0,0,0,0,0,0,1,0,1, 1,3,2,3,2);
    tbl[16] = mk(0,0,0,0,0,0,0,1,0);
    for (int i = 17; i < 22; i++) tbl[i] = mk(1,1,1,1,0,0,0,0,0);
    tbl[22] = mk(1,1,1,2,0,0,1,1,1, 5,5,0,0,0);
    tbl[23] = mk(0,0,0,0,0,0,1,0,1, 1,2,0,0,0);
    tbl[24] = mk(1,1,1,3,0,0,0,0,1, 1,2,0,0,0);

    drive(1,1,1,4,0,0,1,0,7);
    drive(0,0,0,0,0,0,0,0,0);
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].by, tbl[i].er, tbl[i].dr, tbl[i].sn, tbl[i].cl, 0);
      chk($sformatf("v%0d_ack", i), 32'(ack), 32'(tbl[i].sn));
      if (tbl[i].ck) begin
        chk($sformatf("v%0d_frames", i), frames, tbl[i].f);
        chk($sformatf("v%0d_bytes", i), bytes_o, tbl[i].b);
        chk($sformatf("v%0d_errs", i), errs, tbl[i].ef);
        chk($sformatf("v%0d_drops", i), drops, tbl[i].d);
        chk($sformatf("v%0d_proto", i), 32'(proto), tbl[i].p);
      end
    end

    drive(0,0,0,0,0,0,0,0,3);
    chk("hwm_after3", 32'(hwm), 3);
    drive(0,0,0,0,0,0,0,0,9);
    chk("hwm_after9", 32'(hwm), 9);
    drive(0,0,0,0,0,0,0,0,2);
    chk("level_after2", 32'(lvl_o), 2);
    chk("hwm_hold9", 32'(hwm), 9);
    drive(0,0,0,0,0,0,0,1,2);
    chk("hwm_clr_reload", 32'(hwm), 2);
    chk("level_clr", 32'(lvl_o), 2);

    drive(0,0,0,0,0,0,0,1,0);
    for (int i = 0; i < 17; i++) drive(0,0,0,0,0,1,0,0,0);
    drive(0,0,0,0,0,0,1,0,0);
    chk("sat_drops_w4", 32'(drops4), 15);
    chk("sat_drops_w32", drops, 17);
    chk("sat_ack_w4", 32'(ack4), 1);

    rst = 1'b1;
    drive(1,1,1,4,0,1,1,0,5);
    check_zero("rst_prio");
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
